// File: rtl/fft_8_reorder.sv
// Output reorder buffer for the 8-point SDF FFT: bit-reversed serial input in,
// natural-order frames out, ping-pong over two 8-entry banks.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for bank rbank to be marked full
// READ  | draining bank rbank entry rcnt into the output register
module fft_8_reorder #(
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_real,
   input  logic signed [DW-1:0] in_imag,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_real,
   output logic signed [DW-1:0] out_imag,
   output logic [2:0]           out_index,
   output logic                 out_last
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] READ = 1'b1;

   // {bank, entry} addressing; contents are intentionally not reset
   logic [2*DW-1:0] mem_q [16];

   logic [0:0]          state_q, state_d;
   logic [2:0]          wcnt_q, wcnt_d;
   logic                wbank_q, wbank_d;
   logic [2:0]          rcnt_q, rcnt_d;
   logic                rbank_q, rbank_d;
   logic [1:0]          full_q, full_d;
   logic                out_valid_q, out_valid_d;
   logic signed [DW-1:0] out_real_q, out_real_d;
   logic signed [DW-1:0] out_imag_q, out_imag_d;
   logic [2:0]          out_index_q, out_index_d;
   logic                out_last_q, out_last_d;

   logic                wr_en;
   logic [3:0]          wr_addr;
   logic [2*DW-1:0]     wr_word;
   logic [2*DW-1:0]     rd_word;

   always_comb begin
      wr_en   = in_valid;
      wr_addr = {wbank_q, wcnt_q[0], wcnt_q[1], wcnt_q[2]};
      wr_word = {in_real, in_imag};
      rd_word = mem_q[{rbank_q, rcnt_q}];
   end

   always_comb begin
      wcnt_d      = wcnt_q;
      wbank_d     = wbank_q;
      full_d      = full_q;
      state_d     = state_q;
      rcnt_d      = rcnt_q;
      rbank_d     = rbank_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_real_d  = out_real_q;
      out_imag_d  = out_imag_q;
      out_index_d = out_index_q;

      case (state_q)
         IDLE: begin
            rcnt_d = 3'd0;
            if (full_q[rbank_q]) begin
               state_d = READ;
            end
         end
         READ: begin
            out_valid_d = 1'b1;
            out_real_d  = rd_word[2*DW-1:DW];
            out_imag_d  = rd_word[DW-1:0];
            out_index_d = rcnt_q;
            out_last_d  = (rcnt_q == 3'd7);
            rcnt_d      = rcnt_q + 3'd1;
            if (rcnt_q == 3'd7) begin
               full_d[rbank_q] = 1'b0;
               rbank_d         = ~rbank_q;
               // back-to-back only if the other bank completed before this edge
               if (!full_q[~rbank_q]) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (in_valid) begin
         wcnt_d = wcnt_q + 3'd1;
         if (wcnt_q == 3'd7) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wcnt_q      <= 3'd0;
         wbank_q     <= 1'b0;
         rcnt_q      <= 3'd0;
         rbank_q     <= 1'b0;
         full_q      <= 2'b00;
         out_valid_q <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
         out_index_q <= 3'd0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         wbank_q     <= wbank_d;
         rcnt_q      <= rcnt_d;
         rbank_q     <= rbank_d;
         full_q      <= full_d;
         out_valid_q <= out_valid_d;
         out_real_q  <= out_real_d;
         out_imag_q  <= out_imag_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_real  = out_real_q;
   assign out_imag  = out_imag_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;

endmodule
